// File: rtl/mc_column_scheduler.sv
// ---------------------------------------------------------------------------
// mc_column_scheduler
//
// Purpose:
//   Time-multiplexed MixColumns stage for a 128-bit AES state. COLS_PER_CYCLE
//   single-column MixColumns units are reused across the four columns, so a
//   state takes NSTEP = 4/COLS_PER_CYCLE BUSY cycles. Sits between
//   SubBytes/ShiftRows and AddRoundKey. Both sides use valid/ready.
//
// Parameters:
//   COLS_PER_CYCLE : columns transformed per BUSY cycle (1, 2 or 4 only)
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    in_data is valid
//   in_ready   out  1    block accepts a state this cycle
//   in_data    in   128  byte i = bits [8i+7:8i]; column c = bytes 4c..4c+3
//   out_valid  out  1    out_data holds a completed state
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  MixColumns(in_data), same layout (registered)
//   busy       out  1    FSM not IDLE
//   in_bypass  in   1    (only with MC_SCHED_BYPASS_EN) pass columns through
//                        unchanged with identical latency (final AES round)
//
// Configuration macro:
//   MC_SCHED_BYPASS_EN : adds the in_bypass port and pass-through behaviour.
// ---------------------------------------------------------------------------
module mc_column_scheduler #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef MC_SCHED_BYPASS_EN
    ,
    input  logic         in_bypass
`endif
);

    localparam int NSTEP = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mc_column_scheduler: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        fsm_q, fsm_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [127:0]  data_q, data_d;
    logic          load;
    logic          byp_q;

    // GF(2^8) multiply by 2 with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; 3*b is computed as xtime(b)^b.
    function automatic logic [31:0] mc_col(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] o0, o1, o2, o3;
        b0 = c[7:0];
        b1 = c[15:8];
        b2 = c[23:16];
        b3 = c[31:24];
        o0 = xtime(b0) ^ (xtime(b1) ^ b1) ^ b2 ^ b3;
        o1 = b0 ^ xtime(b1) ^ (xtime(b2) ^ b2) ^ b3;
        o2 = b0 ^ b1 ^ xtime(b2) ^ (xtime(b3) ^ b3);
        o3 = (xtime(b0) ^ b0) ^ b1 ^ b2 ^ xtime(b3);
        return {o3, o2, o1, o0};
    endfunction

    // Shared MC units: unit gi works on column cnt*CPC+gi in the current step.
    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_unit
            assign col_idx[gi] = 2'(int'(cnt_q) * COLS_PER_CYCLE + gi);
            assign col_in[gi]  = data_q[{col_idx[gi], 5'b0} +: 32];
            assign col_out[gi] = byp_q ? col_in[gi] : mc_col(col_in[gi]);
        end
    endgenerate

    // Next-state, datapath and handshake outputs. in_ready depends only on
    // the FSM state and out_ready, never on in_valid.
    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (fsm_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load  = 1'b1;
                    cnt_d = 2'd0;
                    fsm_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int u = 0; u < COLS_PER_CYCLE; u++) begin
                    data_d[{col_idx[u], 5'b0} +: 32] = col_out[u];
                end
                if (cnt_q == LAST_STEP) begin
                    fsm_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        // Back-to-back: output retires and next state loads on one edge.
                        load  = 1'b1;
                        cnt_d = 2'd0;
                        fsm_d = S_BUSY;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end
            end
            default: begin
                fsm_d = S_IDLE;
                busy  = 1'b0;
            end
        endcase
        if (load) begin
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= S_IDLE;
            cnt_q  <= 2'd0;
            data_q <= 128'd0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

`ifdef MC_SCHED_BYPASS_EN
    logic byp_d;
    assign byp_d = load ? in_bypass : byp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_q <= 1'b0;
        end else begin
            byp_q <= byp_d;
        end
    end
`else
    assign byp_q = 1'b0;
`endif

    assign out_data = data_q;

endmodule

// File: tb/tb_mc_column_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mc_column_scheduler
//
// Self-checking bench for mc_column_scheduler. Three instances (CPC = 1, 2, 4)
// share clock and reset. Expected values come from known-answer constants and
// a reference MixColumns model built from a general GF(2^8) multiplier and
// the circulant {2,3,1,1} matrix.
// ---------------------------------------------------------------------------
module tb_mc_column_scheduler;

    logic clk;
    logic rst;

    // CPC = 1 instance
    logic         iv1, ir1, ov1, or1, bz1, bp1;
    logic [127:0] id1, od1;
    // CPC = 2 instance
    logic         iv2, ir2, ov2, or2, bz2, bp2;
    logic [127:0] id2, od2;
    // CPC = 4 instance
    logic         iv4, ir4, ov4, or4, bz4, bp4;
    logic [127:0] id4, od4;

    int n_tests = 0;
    int n_fail  = 0;

    mc_column_scheduler #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(bz1)
`ifdef MC_SCHED_BYPASS_EN
        , .in_bypass(bp1)
`endif
    );

    mc_column_scheduler #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .busy(bz2)
`ifdef MC_SCHED_BYPASS_EN
        , .in_bypass(bp2)
`endif
    );

    mc_column_scheduler #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(bz4)
`ifdef MC_SCHED_BYPASS_EN
        , .in_bypass(bp4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mc(input logic [127:0] s);
        int         coef [4];
        logic [7:0] acc;
        logic [127:0] r;
        coef = '{2, 3, 1, 1};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(8'(coef[(k - row + 4) % 4]), s[8*(4*c+k) +: 8]);
                end
                r[8*(4*c+row) +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        iv1 = 0; iv2 = 0; iv4 = 0;
        or1 = 0; or2 = 0; or4 = 0;
        bp1 = 0; bp2 = 0; bp4 = 0;
        id1 = '0; id2 = '0; id4 = '0;
        #12;
        n_tests++; if (ov1 !== 1'b0 || bz1 !== 1'b0 || ir1 !== 1'b1) begin n_fail++; $display("FAIL reset_cpc1: ov=%b busy=%b ir=%b expected 0 0 1", ov1, bz1, ir1); end
        n_tests++; if (od1 !== 128'd0) begin n_fail++; $display("FAIL reset_data_cpc1: got %h expected 0", od1); end
        n_tests++; if (ov2 !== 1'b0 || bz2 !== 1'b0 || ir2 !== 1'b1) begin n_fail++; $display("FAIL reset_cpc2: ov=%b busy=%b ir=%b expected 0 0 1", ov2, bz2, ir2); end
        n_tests++; if (ov4 !== 1'b0 || bz4 !== 1'b0 || ir4 !== 1'b1) begin n_fail++; $display("FAIL reset_cpc4: ov=%b busy=%b ir=%b expected 0 0 1", ov4, bz4, ir4); end
        rst = 1'b0;
        tick();
        n_tests++; if (ov1 !== 1'b0 || bz1 !== 1'b0 || ir1 !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: ov=%b busy=%b ir=%b expected 0 0 1", ov1, bz1, ir1); end
        $display("[TB] reset done");
    endtask

    task automatic test_vector_cpc1();
        logic [127:0] din;
        logic [127:0] exp_kat;
        din     = {32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db};
        exp_kat = {32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e};
        id1 = din; iv1 = 1'b1; or1 = 1'b0;
        n_tests++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL vec1_in_ready: got %b expected 1", ir1); end
        tick();
        iv1 = 1'b0;
        n_tests++; if (bz1 !== 1'b1 || ir1 !== 1'b0) begin n_fail++; $display("FAIL vec1_busy: busy=%b ir=%b expected 1 0", bz1, ir1); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) begin
                n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL vec1_early_valid edge %0d: got %b expected 0", i, ov1); end
            end else begin
                n_tests++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL vec1_latency: out_valid=%b expected 1", ov1); end
                n_tests++; if (od1 !== exp_kat || od1 !== ref_mc(din)) begin n_fail++; $display("FAIL vec1_data: got %h expected %h", od1, exp_kat); end
            end
            if (i == 1) begin
                n_tests++; if (od1[31:0] !== 32'hbca14d8e) begin n_fail++; $display("FAIL vec1_col0_step1: got %h expected bca14d8e", od1[31:0]); end
            end
        end
        $display("[TB] vec1 in=%h out=%h", din, od1);
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        n_tests++; if (ov1 !== 1'b0 || bz1 !== 1'b0) begin n_fail++; $display("FAIL vec1_return_idle: ov=%b busy=%b expected 0 0", ov1, bz1); end
    endtask

    task automatic test_vector_cpc4();
        logic [127:0] din;
        logic [127:0] exp_kat;
        din     = {32'h4c31262d, 32'hd5d4d4d4, 32'hc6c6c6c6, 32'h5c220af2};
        exp_kat = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'hc6c6c6c6, 32'h9d58dc9f};
        id4 = din; iv4 = 1'b1; or4 = 1'b0;
        tick();
        iv4 = 1'b0;
        n_tests++; if (ov4 !== 1'b0 || bz4 !== 1'b1) begin n_fail++; $display("FAIL vec2_busy: ov=%b busy=%b expected 0 1", ov4, bz4); end
        tick();
        n_tests++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL vec2_latency: out_valid=%b expected 1", ov4); end
        n_tests++; if (od4 !== exp_kat || od4 !== ref_mc(din)) begin n_fail++; $display("FAIL vec2_data: got %h expected %h", od4, exp_kat); end
        $display("[TB] vec2 in=%h out=%h", din, od4);
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
    endtask

    task automatic test_hold();
        logic [127:0] a;
        logic [127:0] b;
        a = rand128();
        b = rand128();
        id1 = a; iv1 = 1'b1; or1 = 1'b0;
        tick();
        iv1 = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (ov1 !== 1'b1 || ir1 !== 1'b0) begin n_fail++; $display("FAIL hold_flags cycle %0d: ov=%b ir=%b expected 1 0", i, ov1, ir1); end
            n_tests++; if (od1 !== ref_mc(a)) begin n_fail++; $display("FAIL hold_data cycle %0d: got %h expected %h", i, od1, ref_mc(a)); end
            tick();
        end
        $display("[TB] hold out=%h", od1);
        id1 = b; iv1 = 1'b1; or1 = 1'b1;
        #1;
        n_tests++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1", ir1); end
        @(posedge clk); #1;
        iv1 = 1'b0; or1 = 1'b0;
        n_tests++; if (ov1 !== 1'b0 || bz1 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: ov=%b busy=%b expected 0 1", ov1, bz1); end
        repeat (4) tick();
        n_tests++; if (ov1 !== 1'b1 || od1 !== ref_mc(b)) begin n_fail++; $display("FAIL b2b_data: ov=%b got %h expected %h", ov1, od1, ref_mc(b)); end
        $display("[TB] b2b in=%h out=%h", b, od1);
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] a;
        logic [127:0] b;
        a = rand128();
        b = rand128();
        id2 = a; iv2 = 1'b1; or2 = 1'b1;
        tick();
        iv2 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_tests++; if (ov2 !== 1'b0 || bz2 !== 1'b0 || ir2 !== 1'b1) begin n_fail++; $display("FAIL midrst_flags: ov=%b busy=%b ir=%b expected 0 0 1", ov2, bz2, ir2); end
        n_tests++; if (od2 !== 128'd0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", od2); end
        #2;
        rst = 1'b0;
        id2 = b; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        tick();
        n_tests++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL midrst_early: out_valid=%b expected 0", ov2); end
        tick();
        n_tests++; if (ov2 !== 1'b1 || od2 !== ref_mc(b)) begin n_fail++; $display("FAIL midrst_next: ov=%b got %h expected %h", ov2, od2, ref_mc(b)); end
        $display("[TB] midrst in=%h out=%h", b, od2);
        tick();
        or2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [$];
        logic [127:0] e;
        int sent;
        int recv;
        int cyc;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 1000 && cyc < 30000) begin
            iv1 = (sent < 1000) && ($urandom_range(0, 3) != 0);
            id1 = rand128();
            or1 = 1'($urandom_range(0, 1));
            #1;
            if (iv1 && ir1) begin
                exp_q.push_back(ref_mc(id1));
                sent++;
            end
            if (ov1 && or1) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL stream_extra: unexpected output %h", od1);
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (od1 !== e) begin n_fail++; $display("FAIL stream_data #%0d: got %h expected %h", recv, od1, e); end
                    else $display("[TB] stream #%0d out=%h", recv, od1);
                end
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        iv1 = 1'b0;
        or1 = 1'b0;
        n_tests++; if (recv !== 1000 || exp_q.size() != 0) begin n_fail++; $display("FAIL stream_count: received %0d pending %0d expected 1000 0", recv, exp_q.size()); end
    endtask

`ifdef MC_SCHED_BYPASS_EN
    task automatic test_bypass();
        logic [127:0] din;
        din = {32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db};
        id1 = din; iv1 = 1'b1; bp1 = 1'b1; or1 = 1'b0;
        tick();
        iv1 = 1'b0; bp1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) begin
                n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL bypass_early edge %0d: got %b expected 0", i, ov1); end
            end
        end
        n_tests++; if (ov1 !== 1'b1 || od1 !== din) begin n_fail++; $display("FAIL bypass_data: ov=%b got %h expected %h", ov1, od1, din); end
        $display("[TB] bypass in=%h out=%h", din, od1);
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_vector_cpc1();
        test_vector_cpc4();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef MC_SCHED_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
